fiber_sram_arbiter: RTL and testbench

- Shares one single-port SRAM macro (64-bit word, 9-bit address, 1-cycle read latency) between a write requester (write scanner side) and a read requester (read scanner side) of a fiber access tile.
- Grants at most one memory op per cycle and returns read data through a small credit-checked return buffer with valid/ready.
- Sits between the scanners/buffet and `sram_sp`, replacing direct `wen_to_mem`/`ren_to_mem` wiring.

---
 rtl/fiber_arb_pkg.sv | 18 +
 rtl/fiber_ret_fifo.sv | 72 +++++++
 rtl/fiber_sram_arbiter.sv | 148 ++++++++++++++
 tb/tb_fiber_sram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fiber_arb_pkg.sv
// Shared types and sizing helpers for the fiber SRAM arbiter and its return FIFO.
package fiber_arb_pkg;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_ADDR_W = 9;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WR   = 2'd1,
    GRANT_RD   = 2'd2
  } grant_t;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fiber_ret_fifo.sv
// Small synchronous FIFO for returned SRAM read words; honours clk_en and flush.
module fiber_ret_fifo
  import fiber_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en_i,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [DATA_W-1:0]           push_data_i,
  input  logic                        pop_i,
  output logic [DATA_W-1:0]           head_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is only accepted when a pop frees a slot the same cycle.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clk_en_i) begin
      if (flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (do_push) begin
          mem_q[wptr_q] <= push_data_i;
          wptr_q        <= wptr_q + PTR_W'(1);
        end
        if (do_pop) begin
          rptr_q <= rptr_q + PTR_W'(1);
        end
        cnt_q <= cnt_d;
      end
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fiber_sram_arbiter.sv
// Single-port SRAM arbiter between write and read scanners with a credit-checked read return buffer.
// Define FIBER_ARB_WR_PRIORITY_EN for strict write priority instead of round-robin.
module fiber_sram_arbiter
  import fiber_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned RET_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              rd_data_ready,
  input  logic [DATA_W-1:0] data_from_mem,
  output logic [ADDR_W-1:0] addr_to_mem,
  output logic [DATA_W-1:0] data_to_mem,
  output logic              wen_to_mem,
  output logic              ren_to_mem
);

  localparam int unsigned CNT_W = cnt_width(RET_DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  grant_t            grant_c;
  logic              live_c;
  logic              credit_ok_c;
  logic              wr_ok_c;
  logic              rd_ok_c;
  logic              inflight_q;
  logic              inflight_d;
  logic [CNT_W-1:0]  ret_cnt;
  logic [DATA_W-1:0] ret_head;
  logic              ret_valid;
  logic              ret_pop;

  // Requests are only eligible out of reset, with the clock enabled and no flush pending.
  assign live_c      = rst_n && clk_en && !flush;
  assign credit_ok_c = (SUM_W'(ret_cnt) + SUM_W'(inflight_q)) < SUM_W'(RET_DEPTH);
  assign wr_ok_c     = wr_valid && live_c;
  assign rd_ok_c     = rd_valid && live_c && credit_ok_c;

`ifdef FIBER_ARB_WR_PRIORITY_EN
  always_comb begin
    grant_c = GRANT_NONE;
    if (wr_ok_c) begin
      grant_c = GRANT_WR;
    end else if (rd_ok_c) begin
      grant_c = GRANT_RD;
    end
  end
`else
  grant_t last_grant_q;
  grant_t last_grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_RD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Round-robin only advances on cycles where both sides are actually eligible.
  always_comb begin
    grant_c      = GRANT_NONE;
    last_grant_d = last_grant_q;
    if (wr_ok_c && rd_ok_c) begin
      if (last_grant_q == GRANT_RD) begin
        grant_c = GRANT_WR;
      end else begin
        grant_c = GRANT_RD;
      end
      last_grant_d = grant_c;
    end else if (wr_ok_c) begin
      grant_c = GRANT_WR;
    end else if (rd_ok_c) begin
      grant_c = GRANT_RD;
    end
    if (clk_en && flush) begin
      last_grant_d = GRANT_RD;
    end
  end
`endif

  assign wr_ready   = (grant_c == GRANT_WR);
  assign rd_ready   = (grant_c == GRANT_RD);
  assign wen_to_mem = (grant_c == GRANT_WR);
  assign ren_to_mem = (grant_c == GRANT_RD);

  always_comb begin
    addr_to_mem = '0;
    data_to_mem = '0;
    if (grant_c == GRANT_WR) begin
      addr_to_mem = wr_addr;
      data_to_mem = wr_data;
    end else if (grant_c == GRANT_RD) begin
      addr_to_mem = rd_addr;
    end
  end

  // Marks that data_from_mem carries a granted read word; held while clk_en is low.
  always_comb begin
    inflight_d = inflight_q;
    if (clk_en) begin
      inflight_d = !flush && (grant_c == GRANT_RD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign ret_pop = ret_valid && rd_data_ready;

  fiber_ret_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RET_DEPTH)
  ) u_ret_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en_i    (clk_en),
    .flush_i     (flush),
    .push_i      (inflight_q),
    .push_data_i (data_from_mem),
    .pop_i       (ret_pop),
    .head_o      (ret_head),
    .count_o     (ret_cnt)
  );

  assign ret_valid     = (ret_cnt != '0);
  assign rd_data_valid = ret_valid;
  assign rd_data       = ret_valid ? ret_head : '0;

endmodule

// File: tb/tb_fiber_sram_arbiter.sv
// Directed bench for fiber_sram_arbiter with an SRAM model and a queue-based reference model.
module tb_fiber_sram_arbiter;

  localparam int RET_DEPTH = 2;
`ifdef FIBER_ARB_WR_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clk_en, flush;
  logic [8:0]  wr_addr, rd_addr, addr_to_mem;
  logic [63:0] wr_data, rd_data, data_from_mem, data_to_mem;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic        rd_data_valid, rd_data_ready, wen_to_mem, ren_to_mem;

  int npass = 0;
  int nchk  = 0;

  always #5 clk = ~clk;

  fiber_sram_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_en        (clk_en),
    .flush         (flush),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .rd_data_ready (rd_data_ready),
    .data_from_mem (data_from_mem),
    .addr_to_mem   (addr_to_mem),
    .data_to_mem   (data_to_mem),
    .wen_to_mem    (wen_to_mem),
    .ren_to_mem    (ren_to_mem)
  );

  // Single-port SRAM, one-cycle read latency, frozen by clk_en.
  logic [63:0] sram [512];
  logic [63:0] sram_q = 64'h0;
  always @(posedge clk) begin
    if (clk_en) begin
      if (wen_to_mem) sram[addr_to_mem] <= data_to_mem;
      if (ren_to_mem) sram_q <= sram[addr_to_mem];
    end
  end
  assign data_from_mem = sram_q;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference model: memory contents, queue of words owed to the consumer, one pending read.
  logic [63:0] ref_mem [512];
  logic [63:0] mq[$];
  logic [63:0] n_mq[$];
  logic [63:0] pop_log[$];
  bit          pend = 1'b0, n_pend = 1'b0, last_rd = 1'b1, n_last = 1'b1, mem_we = 1'b0;
  logic [63:0] pd = 64'h0, n_pd = 64'h0, mem_wd = 64'h0;
  logic [8:0]  mem_wa = 9'h0;
  int          credit;
  bit          m_rd_ok, m_wr_ok, e_wg, e_rg;
  logic [63:0] e_addr, e_data, e_rdata;

  initial begin
    for (int i = 0; i < 512; i++) begin
      sram[i]    = 64'hD000_0000_0000_0000 | 64'(i);
      ref_mem[i] = 64'hD000_0000_0000_0000 | 64'(i);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete(); n_mq.delete();
      pend = 1'b0; n_pend = 1'b0; last_rd = 1'b1; n_last = 1'b1; mem_we = 1'b0;
      chk("m_rst_wr_ready", wr_ready, 0);
      chk("m_rst_rd_ready", rd_ready, 0);
      chk("m_rst_wen", wen_to_mem, 0);
      chk("m_rst_ren", ren_to_mem, 0);
      chk("m_rst_addr", addr_to_mem, 0);
      chk("m_rst_wdata", data_to_mem, 0);
      chk("m_rst_rvalid", rd_data_valid, 0);
      chk("m_rst_rdata", rd_data, 0);
    end else begin
      credit  = mq.size() + int'(pend);
      m_wr_ok = wr_valid && clk_en && !flush;
      m_rd_ok = rd_valid && clk_en && !flush && (credit < RET_DEPTH);
      e_wg    = m_wr_ok && (!m_rd_ok || PRIO || last_rd);
      e_rg    = m_rd_ok && !e_wg;
      e_addr  = e_wg ? 64'(wr_addr) : (e_rg ? 64'(rd_addr) : 64'h0);
      e_data  = e_wg ? wr_data : 64'h0;
      e_rdata = (mq.size() > 0) ? mq[0] : 64'h0;
      chk("m_wr_ready", wr_ready, e_wg);
      chk("m_rd_ready", rd_ready, e_rg);
      chk("m_wen", wen_to_mem, e_wg);
      chk("m_ren", ren_to_mem, e_rg);
      chk("m_addr", addr_to_mem, e_addr);
      chk("m_wdata", data_to_mem, e_data);
      chk("m_rvalid", rd_data_valid, mq.size() > 0);
      chk("m_rdata", rd_data, e_rdata);
      n_mq = mq; n_pend = pend; n_pd = pd; n_last = last_rd; mem_we = 1'b0;
      if (clk_en) begin
        if (flush) begin
          n_mq.delete(); n_pend = 1'b0; n_last = 1'b1;
        end else begin
          if (mq.size() > 0 && rd_data_ready) begin
            pop_log.push_back(mq[0]);
            void'(n_mq.pop_front());
          end
          if (pend) n_mq.push_back(pd);
          n_pend = e_rg;
          if (e_rg) n_pd = ref_mem[rd_addr];
          if (e_wg) begin mem_we = 1'b1; mem_wa = wr_addr; mem_wd = wr_data; end
          if (m_wr_ok && m_rd_ok) n_last = e_rg;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      mq = n_mq; pend = n_pend; pd = n_pd; last_rd = n_last;
      if (mem_we) ref_mem[mem_wa] = mem_wd;
      mem_we = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0; rd_valid = 1'b0; flush = 1'b0; clk_en = 1'b1;
  endtask

  task automatic write_burst(input logic [63:0] base);
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1; wr_addr = 9'(k); wr_data = base + 64'(k); rd_valid = 1'b0;
      #1;
      chk("wburst_wr_ready", wr_ready, 1);
      chk("wburst_wen", wen_to_mem, 1);
      chk("wburst_ren", ren_to_mem, 0);
      chk("wburst_addr", addr_to_mem, 64'(k));
      chk("wburst_data", data_to_mem, base + 64'(k));
      cyc();
    end
    idle();
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: got no finish, expected finish before 50000");
    $fatal(1, "bench timeout");
  end

  int          a, guard;
  logic [63:0] e2 [4];
  int          n2;

  initial begin
    rst_n = 1'b1; clk_en = 1'b1; flush = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; rd_data_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rvalid", rd_data_valid, 0);
    chk("rst_rdata", rd_data, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Scenario 1: write only
    write_burst(64'hA0);
    cyc();

    // Scenario 2: contention, write and read of addr 5
    pop_log.delete();
    for (int k = 0; k < 6; k++) begin
      wr_valid = 1'b1; wr_addr = 9'd5; wr_data = 64'h5500 + 64'(k);
      rd_valid = 1'b1; rd_addr = 9'd5; rd_data_ready = 1'b1;
      #1;
      chk("rr_wr_grant", wr_ready, PRIO ? 1'b1 : (k % 2 == 0));
      chk("rr_rd_grant", rd_ready, PRIO ? 1'b0 : (k % 2 == 1));
      cyc();
    end
    wr_valid = 1'b0;
    #1 chk("rr_read_alone", rd_ready, 1);
    cyc();
    idle();
    repeat (4) cyc();
    n2 = PRIO ? 1 : 4;
    e2[0] = PRIO ? 64'h5505 : 64'h5500;
    e2[1] = 64'h5502; e2[2] = 64'h5504; e2[3] = 64'h5504;
    chk("rr_pop_count", 64'(pop_log.size()), 64'(n2));
    for (int i = 0; i < n2; i++)
      chk("rr_pop_data", (i < pop_log.size()) ? pop_log[i] : 64'h0, e2[i]);

    // Scenario 3: backpressure
    pop_log.delete();
    rd_data_ready = 1'b0; a = 10;
    for (int k = 0; k < 6; k++) begin
      rd_valid = 1'b1; rd_addr = 9'(a);
      #1;
      chk("bp_rd_ready", rd_ready, k < 2);
      if (rd_ready) a++;
      cyc();
    end
    chk("bp_granted", 64'(a), 64'd12);
    rd_data_ready = 1'b1; guard = 0;
    while (a < 16 && guard < 30) begin
      rd_addr = 9'(a);
      #1;
      if (guard == 0) chk("bp_release_blocked", rd_ready, 0);
      if (guard == 1) chk("bp_resume", rd_ready, 1);
      if (rd_ready) a++;
      cyc();
      guard++;
    end
    chk("bp_all_granted", 64'(a), 64'd16);
    idle();
    repeat (4) cyc();
    chk("bp_pop_count", 64'(pop_log.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      chk("bp_pop_data", (i < pop_log.size()) ? pop_log[i] : 64'h0,
          64'hD000_0000_0000_000A + 64'(i));

    // Scenario 4: clk_en stall with a read in flight
    wr_valid = 1'b1; wr_addr = 9'd20; wr_data = 64'h1234_5678_9ABC_DEF0;
    cyc();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 9'd20;
    #1 chk("ce_rd_grant", rd_ready, 1);
    cyc();
    clk_en = 1'b0; wr_valid = 1'b1; wr_addr = 9'd21; rd_addr = 9'd21;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ce_no_wr", wr_ready, 0);
      chk("ce_no_rd", rd_ready, 0);
      chk("ce_rvalid_frozen", rd_data_valid, 0);
      cyc();
    end
    idle();
    #1 chk("ce_resume_rvalid", rd_data_valid, 0);
    cyc();
    #1;
    chk("ce_word_valid", rd_data_valid, 1);
    chk("ce_word_data", rd_data, 64'h1234_5678_9ABC_DEF0);
    cyc();
    #1 chk("ce_drained", rd_data_valid, 0);
    cyc();

    // Scenario 5: flush with one word buffered and one in flight
    pop_log.delete();
    rd_data_ready = 1'b0; rd_valid = 1'b1; rd_addr = 9'd30;
    #1 chk("fl_rd30", rd_ready, 1);
    cyc();
    rd_addr = 9'd31;
    #1 chk("fl_rd31", rd_ready, 1);
    cyc();
    flush = 1'b1; wr_valid = 1'b1; wr_addr = 9'd50; wr_data = 64'hF1;
    #1;
    chk("fl_pre_rvalid", rd_data_valid, 1);
    chk("fl_no_wr", wr_ready, 0);
    chk("fl_no_rd", rd_ready, 0);
    cyc();
    flush = 1'b0; rd_addr = 9'd32;
    #1;
    chk("fl_empty", rd_data_valid, 0);
    chk("fl_wr_wins", wr_ready, 1);
    chk("fl_rd_loses", rd_ready, 0);
    cyc();
    idle(); rd_data_ready = 1'b1;
    repeat (3) cyc();
    chk("fl_no_pops", 64'(pop_log.size()), 64'd0);

    // Scenario 6: async reset mid-burst, then write burst again
    rd_data_ready = 1'b0; rd_valid = 1'b1; rd_addr = 9'd33;
    cyc();
    rd_valid = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1; wr_addr = 9'(40 + k); wr_data = 64'hC0 + 64'(k);
      #1;
      chk("ar_wr_ready", wr_ready, 1);
      if (k == 2) begin
        chk("ar_pre_rvalid", rd_data_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_wr_ready0", wr_ready, 0);
        chk("ar_wen0", wen_to_mem, 0);
        chk("ar_addr0", addr_to_mem, 0);
        chk("ar_wdata0", data_to_mem, 0);
        chk("ar_rvalid0", rd_data_valid, 0);
        chk("ar_rdata0", rd_data, 0);
      end
      cyc();
    end
    idle(); rd_data_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    write_burst(64'hB0);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
